// File: rtl/prog_mem_loader_if.sv
// Byte-stream receive handshake plus program-memory write port for prog_mem_loader.
// The loader uses the master view and the UART/memory side uses the slave view.
interface prog_mem_loader_if #(
   parameter int ADDR_W = 14
);
   logic [7:0]        rx_data;
   logic              rx_valid;
   logic              rx_ready;
   logic              pm_we;
   logic [ADDR_W-1:0] pm_addr;
   logic [15:0]       pm_din;

   modport master (
      input  rx_data, rx_valid,
      output rx_ready, pm_we, pm_addr, pm_din
   );

   modport slave (
      output rx_data, rx_valid,
      input  rx_ready, pm_we, pm_addr, pm_din
   );
endinterface

// File: rtl/prog_mem_loader.sv
// Loads a little-endian byte stream into 16-bit program memory while holding the CPU in reset.
// Define PROG_LOADER_CKSUM_EN to require a trailing checksum byte and report mismatches on err_o.
module prog_mem_loader #(
   parameter int ADDR_W = 14,
   parameter int CNT_W  = 15
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start_i,
   input  logic [ADDR_W-1:0] base_addr_i,
   input  logic [CNT_W-1:0]  word_count_i,
   prog_mem_loader_if.master bus,
   output logic              cpu_hold_o,
   output logic              busy_o,
   output logic              done_o,
   output logic              err_o
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LO,
      ST_HI,
      ST_WRITE,
`ifdef PROG_LOADER_CKSUM_EN
      ST_CKSUM,
`endif
      ST_FIN
   } state_t;

   // State entered once the last data word has been written (or immediately for a zero count).
`ifdef PROG_LOADER_CKSUM_EN
   localparam state_t ST_TAIL = ST_CKSUM;
`else
   localparam state_t ST_TAIL = ST_FIN;
`endif

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [CNT_W-1:0]  rem_q, rem_d;
   logic [7:0]        lo_q, lo_d;
   logic [7:0]        hi_q, hi_d;
   logic              rx_ready_w;
   logic              xfer;

`ifdef PROG_LOADER_CKSUM_EN
   logic [7:0]        sum_q, sum_d;
   logic              err_q, err_d;
`endif

   // Every output is a decode of registered state, so no input reaches an output combinationally.
   always_comb begin
      rx_ready_w = (state_q == ST_LO) || (state_q == ST_HI);
`ifdef PROG_LOADER_CKSUM_EN
      if (state_q == ST_CKSUM) rx_ready_w = 1'b1;
`endif
   end

   assign xfer         = bus.rx_valid & rx_ready_w;
   assign bus.rx_ready = rx_ready_w;
   assign bus.pm_we    = (state_q == ST_WRITE);
   assign bus.pm_addr  = addr_q;
   assign bus.pm_din   = {hi_q, lo_q};
   assign busy_o       = (state_q != ST_IDLE);
   assign cpu_hold_o   = busy_o;
   assign done_o       = (state_q == ST_FIN);
`ifdef PROG_LOADER_CKSUM_EN
   assign err_o        = err_q;
`else
   assign err_o        = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      rem_d   = rem_q;
      lo_d    = lo_q;
      hi_d    = hi_q;
`ifdef PROG_LOADER_CKSUM_EN
      sum_d   = sum_q;
      err_d   = err_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               addr_d  = base_addr_i;
               rem_d   = word_count_i;
`ifdef PROG_LOADER_CKSUM_EN
               sum_d   = 8'h00;
               err_d   = 1'b0;
`endif
               state_d = (word_count_i != '0) ? ST_LO : ST_TAIL;
            end
         end
         ST_LO: begin
            if (xfer) begin
               lo_d    = bus.rx_data;
`ifdef PROG_LOADER_CKSUM_EN
               sum_d   = sum_q + bus.rx_data;
`endif
               state_d = ST_HI;
            end
         end
         ST_HI: begin
            if (xfer) begin
               hi_d    = bus.rx_data;
`ifdef PROG_LOADER_CKSUM_EN
               sum_d   = sum_q + bus.rx_data;
`endif
               state_d = ST_WRITE;
            end
         end
         ST_WRITE: begin
            addr_d  = addr_q + 1'b1;
            rem_d   = rem_q - 1'b1;
            state_d = (rem_q != CNT_W'(1)) ? ST_LO : ST_TAIL;
         end
`ifdef PROG_LOADER_CKSUM_EN
         ST_CKSUM: begin
            if (xfer) begin
               err_d   = ((sum_q + bus.rx_data) != 8'h00);
               state_d = ST_FIN;
            end
         end
`endif
         ST_FIN: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Data registers are reset too so that pm_addr/pm_din read as zero straight out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         rem_q   <= '0;
         lo_q    <= 8'h00;
         hi_q    <= 8'h00;
`ifdef PROG_LOADER_CKSUM_EN
         sum_q   <= 8'h00;
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         rem_q   <= rem_d;
         lo_q    <= lo_d;
         hi_q    <= hi_d;
`ifdef PROG_LOADER_CKSUM_EN
         sum_q   <= sum_d;
         err_q   <= err_d;
`endif
      end
   end

endmodule

// File: tb/tb_prog_mem_loader.sv
// Randomized self-checking bench for prog_mem_loader against a word-level model of the image load.
// Honors PROG_LOADER_CKSUM_EN the same way as the design.
module tb_prog_mem_loader;

   localparam int ADDR_W = 14;
   localparam int CNT_W  = 15;

   typedef struct {
      logic [ADDR_W-1:0] a;
      logic [15:0]       d;
   } wr_t;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic [ADDR_W-1:0] base_addr = '0;
   logic [CNT_W-1:0]  word_count = '0;
   logic              cpu_hold, busy, done, err;

   prog_mem_loader_if #(.ADDR_W(ADDR_W)) bus ();

   prog_mem_loader #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start_i      (start),
      .base_addr_i  (base_addr),
      .word_count_i (word_count),
      .bus          (bus),
      .cpu_hold_o   (cpu_hold),
      .busy_o       (busy),
      .done_o       (done),
      .err_o        (err)
   );

   always #5 clk = ~clk;

   int          vectors = 0;
   int          miscompares = 0;
   int          cyc = 0;
   int          we_cnt, done_cnt, last_we_cyc;
   wr_t         exp_q[$];
   int          hi_q[$];
   logic [7:0]  bytes[$];
   logic [15:0] exp_mem [0:(1<<ADDR_W)-1];
   logic [15:0] dut_mem [0:(1<<ADDR_W)-1];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail_now(input string name, input string what);
      vectors++;
      miscompares++;
      $display("FAIL %s: got %s (cycle %0d)", name, what, cyc);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_rx_ready"}, bus.rx_ready, 0);
      check({tag, "_pm_we"},    bus.pm_we, 0);
      check({tag, "_pm_addr"},  bus.pm_addr, 0);
      check({tag, "_pm_din"},   bus.pm_din, 0);
      check({tag, "_cpu_hold"}, cpu_hold, 0);
      check({tag, "_busy"},     busy, 0);
      check({tag, "_done"},     done, 0);
      check({tag, "_err"},      err, 0);
   endtask

   // Per-cycle comparison of the write port against the queued expected words.
   always @(negedge clk) begin
      if (rst_n) begin
         check("hold_is_busy", cpu_hold, busy);
         if (bus.pm_we) begin
            wr_t w;
            int  h;
            we_cnt++;
            last_we_cyc = cyc;
            check("rdy_in_write", bus.rx_ready, 0);
            if (exp_q.size() == 0) begin
               fail_now("unexpected_we", "write with none pending");
            end else begin
               w = exp_q.pop_front();
               check("pm_addr", bus.pm_addr, w.a);
               check("pm_din", bus.pm_din, w.d);
            end
            if (hi_q.size() != 0) begin
               h = hi_q.pop_front();
               check("we_latency", cyc, h + 1);
            end
            dut_mem[bus.pm_addr] = bus.pm_din;
         end
         if (done) done_cnt++;
      end
   end

   task automatic send_byte(input logic [7:0] b, output int acc_cyc);
      int g = 0;
      bus.rx_valid = 1'b1;
      bus.rx_data  = b;
      while (!bus.rx_ready && g < 100) begin
         @(posedge clk); #1;
         g++;
      end
      if (g >= 100) fail_now("byte_timeout", "no rx_ready within 100 cycles");
      acc_cyc = cyc;
      @(posedge clk); #1;
      bus.rx_valid = 1'b0;
   endtask

   task automatic do_load(input int base, input int cnt, input int stall_word, input int stall_len,
                          input bit gaps, input bit mid_start, input int abort_bytes, input int ck);
      int         sum = 0;
      int         acc, g, d, nbytes, nwords, start_cyc;
      logic [7:0] ckb;
      logic [ADDR_W-1:0] a;
      we_cnt = 0;
      done_cnt = 0;
      last_we_cyc = -10;
      nbytes = (abort_bytes >= 0) ? abort_bytes : 2 * cnt;
      nwords = nbytes / 2;
      for (int i = 0; i < 2 * cnt; i++) sum += bytes[i];
      for (int i = 0; i < nwords; i++) begin
         wr_t w;
         w.a = ADDR_W'((base + i) % (1 << ADDR_W));
         w.d = {bytes[2*i+1], bytes[2*i]};
         exp_q.push_back(w);
         exp_mem[w.a] = w.d;
      end
      ckb = (ck < 0) ? 8'((256 - (sum % 256)) % 256) : 8'(ck);

      start = 1'b1;
      base_addr = ADDR_W'(base);
      word_count = CNT_W'(cnt);
      start_cyc = cyc;
      @(posedge clk); #1;
      start = 1'b0;
      base_addr = ADDR_W'($urandom);
      word_count = CNT_W'($urandom);

      for (int i = 0; i < nbytes; i++) begin
         if (mid_start && i == 2) begin
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
         end
         if (gaps && $urandom_range(0, 2) == 0) begin
            repeat ($urandom_range(1, 3)) begin
               @(posedge clk); #1;
            end
         end
         if (i == 2 * stall_word + 1) begin
            for (int s = 0; s < stall_len; s++) begin
               check("stall_no_we", bus.pm_we, 0);
               @(posedge clk); #1;
            end
         end
         send_byte(bytes[i], acc);
         if (i % 2 == 1) hi_q.push_back(acc);
      end

      if (abort_bytes >= 0) begin
         check("pre_abort_writes", exp_q.size(), 0);
         rst_n = 1'b0;
         #1;
         check_all_zero("async_rst");
         exp_q.delete();
         hi_q.delete();
         @(posedge clk); #1;
         rst_n = 1'b1;
         for (int i = 0; i < nwords; i++) begin
            a = ADDR_W'((base + i) % (1 << ADDR_W));
            check("retained_word", dut_mem[a], exp_mem[a]);
         end
         return;
      end

`ifdef PROG_LOADER_CKSUM_EN
      send_byte(ckb, acc);
`else
      bus.rx_valid = 1'b1;
      bus.rx_data  = ckb;
`endif
      g = 0;
      while (!done && g < 50) begin
`ifndef PROG_LOADER_CKSUM_EN
         check("extra_not_taken", bus.rx_ready, 0);
`endif
         @(posedge clk); #1;
         g++;
      end
      if (g >= 50) fail_now("done_timeout", "no done within 50 cycles");
      d = cyc;
      check("hold_at_done", cpu_hold, 1);
`ifndef PROG_LOADER_CKSUM_EN
      check("done_cycle", d, (cnt > 0) ? last_we_cyc + 1 : start_cyc + 1);
`endif
      @(posedge clk); #1;
      check("extra_not_taken_idle", bus.rx_ready, 0);
      bus.rx_valid = 1'b0;
      check("busy_after_done", busy, 0);
      check("hold_after_done", cpu_hold, 0);
      check("done_one_cycle", done, 0);
      check("done_count", done_cnt, 1);
      check("we_count", we_cnt, cnt);
      check("pending_writes", exp_q.size(), 0);
`ifdef PROG_LOADER_CKSUM_EN
      check("err", err, ((sum + ckb) % 256) != 0);
`else
      check("err", err, 0);
`endif
      for (int i = 0; i < cnt; i++) begin
         a = ADDR_W'((base + i) % (1 << ADDR_W));
         check("mem_word", dut_mem[a], exp_mem[a]);
      end
   endtask

   initial begin
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;
      #1;
      check_all_zero("reset");
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      check_all_zero("idle");

      bytes = '{8'h21, 8'hE2, 8'h04, 8'hE3};
      do_load(0, 2, -1, 0, 0, 0, -1, -1);
      check("basic_w0", dut_mem[0], 16'hE221);
      check("basic_w1", dut_mem[1], 16'hE304);

      bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
      do_load(14'h3FFF, 2, -1, 0, 0, 0, -1, -1);
      check("wrap_hi", dut_mem[14'h3FFF], 16'h2211);
      check("wrap_lo", dut_mem[0], 16'h4433);

      bytes = '{8'hA5, 8'h5A, 8'hC3, 8'h3C};
      do_load(14'h100, 2, 0, 10, 0, 0, -1, -1);

      bytes = '{8'h01, 8'h02};
      do_load(14'h200, 1, -1, 0, 0, 0, -1, 8'hFD);
      check("cksum_ok_word", dut_mem[14'h200], 16'h0201);
      check("cksum_ok_err", err, 0);
      do_load(14'h201, 1, -1, 0, 0, 0, -1, 8'h00);
      check("cksum_bad_word", dut_mem[14'h201], 16'h0201);
`ifdef PROG_LOADER_CKSUM_EN
      check("cksum_bad_err", err, 1);
`endif

      bytes.delete();
      do_load(14'h300, 0, -1, 0, 0, 0, -1, -1);

      bytes = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60};
      do_load(14'h400, 3, -1, 0, 0, 1, -1, -1);

      bytes.delete();
      for (int i = 0; i < 8; i++) bytes.push_back(8'(i * 17 + 3));
      do_load(14'h20, 4, -1, 0, 0, 0, 7, -1);
      bytes = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
      do_load(14'h23, 2, -1, 0, 0, 0, -1, -1);
      check("restart_w0", dut_mem[14'h23], 16'hADDE);

      for (int t = 0; t < 10; t++) begin
         int n;
         n = $urandom_range(1, 6);
         bytes.delete();
         for (int i = 0; i < 2 * n; i++) bytes.push_back(8'($urandom));
         do_load($urandom_range(0, (1 << ADDR_W) - 1), n, $urandom_range(0, n - 1),
                 $urandom_range(0, 4), 1, $urandom_range(0, 1), -1,
                 ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : -1);
      end

      repeat (3) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/prog_mem_loader.md
# prog_mem_loader

Byte-stream loader that writes a program image into the 16-bit-word program memory through its write port (`we`/`addr`/`din`). It is the write-side counterpart to the CPU's instruction fetch. The loader takes bytes from the UART receiver over a valid/ready handshake and packs byte pairs little-endian, so the low byte goes to the even byte address. It then issues one-cycle word writes and holds the CPU in reset until the image is complete.

## Interface
Parameters:
- `ADDR_W`, 14: program memory word-address width.
- `CNT_W`, 15: word-count width. Must hold 2^ADDR_W.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  load request pulse. Sampled only in IDLE.
- `base_addr`  in  ADDR_W  first word address. Captured on an accepted `start`.
- `word_count`  in  CNT_W  number of words to load. Captured on an accepted `start`.
- `rx_data`  in  8  incoming byte.
- `rx_valid`  in  1  `rx_data` is valid.
- `rx_ready`  out  1  loader accepts a byte this cycle.
- `pm_we`  out  1  program memory write strobe.
- `pm_addr`  out  ADDR_W  program memory word address.
- `pm_din`  out  16  write data: `{hi_byte, lo_byte}`.
- `cpu_hold`  out  1  keeps the CPU in reset while a load is in progress.
- `busy`  out  1  the loader is not in IDLE.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  checksum mismatch. Sticky; cleared by the next accepted `start`.

## Operation
- States: IDLE, LO, HI, WRITE, CKSUM, FIN.
- IDLE:
  - `start`=1 captures `base_addr` into the address register and `word_count` into the remaining counter, clears the running sum and clears `err`.
  - Next state is LO if `word_count`≠0. Otherwise next state is CKSUM when the macro is defined, else FIN.
- LO: `rx_ready`=1. A byte transfer occurs when `rx_valid`&`rx_ready`. On a transfer, store `lo_byte`, add it to the sum, and go to HI.
- HI: `rx_ready`=1. On a transfer, store `hi_byte`, add it to the sum, and go to WRITE.
- WRITE:
  - `rx_ready`=0 and `pm_we`=1 for exactly one cycle, with `pm_addr` = address register and `pm_din` = `{hi_byte,lo_byte}`.
  - Increment the address modulo 2^ADDR_W, so 0x3FFF wraps to 0x0000. Decrement the remaining counter.
  - Next state is LO if remaining-1≠0. Otherwise next state is CKSUM when the macro is defined, else FIN.
- CKSUM: `rx_ready`=1. On a transfer, set `err` if (sum + `rx_data`) mod 256 ≠ 0. Then go to FIN.
- FIN: `done`=1 for one cycle and `cpu_hold` stays 1. Next state is IDLE.
- Status outputs:
  - `busy` = (state≠IDLE).
  - `cpu_hold` = `busy`. It deasserts in the cycle after `done`.
- Start handling: `start` outside IDLE is ignored and has no effect on the load in progress.
- Stalls: `rx_valid`=0 in LO, HI or CKSUM stalls indefinitely with no timeout. A byte presented during WRITE is not consumed and is accepted in the following LO cycle.
- Sum: an 8-bit register that wraps on overflow.
- Reset:
  - Applies asynchronously at any time, including mid-load. State returns to IDLE.
  - Every output returns to 0 immediately: `rx_ready`, `pm_we`, `pm_addr`, `pm_din`, `cpu_hold`, `busy`, `done`, `err`.
  - Words already written stay in memory. A partial word (LO byte received but no write yet) is discarded.

## Timing
- `pm_addr`, `pm_din`, `pm_we` and all other outputs are driven from registers. There are no combinational paths from input to output.
- Accepted `start` at cycle 0: state is LO from cycle 1 and `rx_ready`=1 in cycle 1.
- Byte throughput: at most 2 bytes per 3 cycles (LO, HI, WRITE).
- HI byte accepted in cycle n: `pm_we`=1 in cycle n+1.
- Final write in cycle m, macro undefined: `done`=1 in cycle m+1, and `cpu_hold`=0 and `busy`=0 in cycle m+2.
- Write-to-fetch ordering: the memory is synchronous. A word written in cycle m can be fetched from cycle m+1 onward. Because the CPU is released later than that, it cannot fetch stale data.

## Configuration
- `PROG_LOADER_CKSUM_EN` defined:
  - After the last word, one additional checksum byte is required (CKSUM state).
  - `err` flags a mismatch. The image is still written, and `done` still pulses.
- `PROG_LOADER_CKSUM_EN` undefined:
  - The CKSUM state and the sum register are absent, and `err` is tied to 0.
  - The next byte after the last word is not consumed by the loader.

## Test plan
- Basic load: reset, then `start` with `base_addr`=0, `word_count`=2, and bytes 0x21,0xE2,0x04,0xE3 streamed back-to-back. Required: word 0 = 0xE221 and word 1 = 0xE304, `pm_we` pulses in exactly 2 cycles, `done` pulses once, and `cpu_hold` falls the cycle after `done`.
- Wrap-around: `base_addr`=0x3FFF, `word_count`=2, bytes 0x11,0x22,0x33,0x44. Required: writes land at 0x3FFF = 0x2211 and 0x0000 = 0x4433.
- Stall and backpressure: `rx_valid` held low for 10 cycles between the LO and HI bytes. Required: no `pm_we` until the HI byte arrives, and `rx_ready`=0 in every WRITE cycle.
- Checksum (macro defined): data bytes 0x01,0x02 followed by checksum 0xFD. Required: `err`=0. Repeat with checksum 0x00. Required: `err`=1 and the word is still written as 0x0201.
- Zero count and ignored start: `word_count`=0. Required: no `pm_we`, and `done` 1 cycle after `start` (macro undefined). A `start` pulsed mid-load changes neither the address nor the count.
- Reset mid-load: assert `rst_n`=0 after the LO byte of word 3. Required: all outputs are 0 immediately, words 0–2 are retained, and a fresh load restarts correctly.
